// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_pkg
// Brief    : Shared state encodings and default sizing for the reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

  localparam int c_DEF_SYNC_STAGES = 2;
  localparam int c_DEF_NUM_OUT     = 4;
  localparam int c_DEF_STEP_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/rst_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : rst_sync_chain
// Brief    : Asynchronous-assert, synchronous-release reset synchroniser of
//            configurable depth (active-low in and out).
// Revision : 1.0 - initial release
// ============================================================================
module rst_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clkin,
  input  logic i_reset,
  output logic o_reset
);

  logic [SYNC_STAGES-1:0] r_sync;

  generate
    if (SYNC_STAGES < 1) begin : g_bad_depth
      $error("rst_sync_chain: SYNC_STAGES must be at least 1");
    end

    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge i_clkin or negedge i_reset) begin
        if (!i_reset) begin
          r_sync <= 1'b0;
        end else begin
          r_sync <= 1'b1;
        end
      end
    end else begin : g_multi
      always_ff @(posedge i_clkin or negedge i_reset) begin
        if (!i_reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
      end
    end
  endgenerate

  assign o_reset = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_ctrl
// Brief    : Reset synchroniser plus sequencer releasing NUM_OUT active-low
//            resets one by one, STEP_CYCLES apart, with software restart.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = c_DEF_SYNC_STAGES,
  parameter int NUM_OUT     = c_DEF_NUM_OUT,
  parameter int STEP_CYCLES = c_DEF_STEP_CYCLES
) (
  input  logic               i_clkin,
  input  logic               i_reset,
  input  logic               i_sw_rst,
  output logic [NUM_OUT-1:0] o_reset,
  output logic               o_done,
  output logic               o_busy
);

  localparam int c_CNT_W = $clog2(STEP_CYCLES + 1);
  localparam int c_IDX_W = $clog2(NUM_OUT + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STEP_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_OUT - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("rst_seq_ctrl: SYNC_STAGES must be at least 2");
    end
    if (NUM_OUT < 1) begin : g_bad_num
      $error("rst_seq_ctrl: NUM_OUT must be at least 1");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step
      $error("rst_seq_ctrl: STEP_CYCLES must be at least 1");
    end
  endgenerate

  seq_state_t          r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [NUM_OUT-1:0]  r_rst;
  logic                r_done;
  logic                r_busy;
  logic                w_rel_pre;

  // The FSM's exit from ST_HOLD acts as the final synchroniser stage, so the
  // chain supplies the first SYNC_STAGES-1 flops and r_rel coincides with it.
  rst_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES - 1)
  ) u_sync (
    .i_clkin(i_clkin),
    .i_reset(i_reset),
    .o_reset(w_rel_pre)
  );

  always_ff @(posedge i_clkin or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (i_sw_rst && (r_state != ST_HOLD)) begin
      // Software restart beats a release falling on the same edge.
      r_state <= ST_STEP;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_rel_pre) begin
            r_state <= ST_STEP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_STEP: begin
          if (r_cnt == c_CNT_LAST) begin
            r_cnt <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
              if (r_idx == c_IDX_W'(k)) begin
                r_rst[k] <= 1'b1;
              end
            end
            r_idx <= r_idx + c_IDX_W'(1);
            if (r_idx == c_IDX_LAST) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

  assign o_reset = r_rst;
  assign o_done  = r_done;
  assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq_ctrl
// Brief    : Self-checking bench for rst_seq_ctrl (default and minimal sizing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       sw    = 1'b0;
  logic [3:0] rst_a;
  logic       done_a, busy_a;
  logic [0:0] rst_b;
  logic       done_b, busy_b;

  int tests = 0;
  int fails = 0;

  // Reference model state: edge count, edges sampled with reset high, and
  // the edge at which each DUT's current release sequence began.
  int edge_n  = 0;
  int hi_cnt  = 0;
  bit st_a    = 1'b0;
  bit st_b    = 1'b0;
  int start_a = 0;
  int start_b = 0;
  bit cmp_en  = 1'b0;
  int e1;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.SYNC_STAGES(2), .NUM_OUT(4), .STEP_CYCLES(16)) u_dut_a (
    .i_clkin(clk), .i_reset(rst_n), .i_sw_rst(sw),
    .o_reset(rst_a), .o_done(done_a), .o_busy(busy_a)
  );

  rst_seq_ctrl #(.SYNC_STAGES(3), .NUM_OUT(1), .STEP_CYCLES(1)) u_dut_b (
    .i_clkin(clk), .i_reset(rst_n), .i_sw_rst(sw),
    .o_reset(rst_b), .o_done(done_b), .o_busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (rst_n) begin
      hi_cnt++;
      if (st_a) begin
        if (sw) start_a = edge_n;
      end else if (hi_cnt == 2) begin
        st_a = 1'b1; start_a = edge_n;
      end
      if (st_b) begin
        if (sw) start_b = edge_n;
      end else if (hi_cnt == 3) begin
        st_b = 1'b1; start_b = edge_n;
      end
    end
  end

  always @(negedge rst_n) begin
    hi_cnt = 0;
    st_a   = 1'b0;
    st_b   = 1'b0;
  end

  function automatic int n_rel(input bit st, input int start, input int num, input int step);
    int r;
    if (!st) return 0;
    r = (edge_n - start) / step;
    if (r > num) r = num;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      int ra;
      int rb;
      ra = n_rel(st_a, start_a, 4, 16);
      rb = n_rel(st_b, start_b, 1, 1);
      check("cyc_rst_a",  32'(rst_a),  32'((1 << ra) - 1));
      check("cyc_done_a", 32'(done_a), 32'(st_a && (ra == 4)));
      check("cyc_busy_a", 32'(busy_a), 32'(st_a && (ra < 4)));
      check("cyc_rst_b",  32'(rst_b),  32'((1 << rb) - 1));
      check("cyc_done_b", 32'(done_b), 32'(st_b && (rb == 1)));
      check("cyc_busy_b", 32'(busy_b), 32'(st_b && (rb < 1)));
    end
  end

  task automatic goto_e(input int e);
    int guard = 0;
    while ((edge_n < e) && (guard < 1000)) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (edge_n != e) begin
      tests++;
      fails++;
      $display("FAIL goto: at edge %0d, required %0d", edge_n, e);
    end
  endtask

  // Drive sw high so that it is sampled on edges e .. e+len-1.
  task automatic pulse_sw_at(input int e, input int len);
    goto_e(e - 1);
    @(negedge clk);
    sw = 1'b1;
    repeat (len) @(negedge clk);
    sw = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    e1 = edge_n + 1;
  endtask

  initial begin
    int ex;
    int last;
    int col;
    int r;
    bit quiet;

    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // Power-on release
    repeat (5) @(negedge clk);
    check("por_rst_a", 32'(rst_a), 32'h0);
    check("por_done_a", 32'(done_a), 32'h0);
    check("por_busy_a", 32'(busy_a), 32'h0);
    check("por_rst_b", 32'(rst_b), 32'h0);
    release_rst();
    goto_e(e1);       check("p1_busy_e1", 32'(busy_a), 32'h0);
    goto_e(e1 + 1);   check("p1_busy_e2", 32'(busy_a), 32'h1);
                      check("p1_rst_e2",  32'(rst_a),  32'h0);
    goto_e(e1 + 2);   check("b_rst_e3",   32'(rst_b),  32'h0);
    goto_e(e1 + 3);   check("b_rst_e4",   32'(rst_b),  32'h1);
                      check("b_done_e4",  32'(done_b), 32'h1);
    goto_e(e1 + 16);  check("p1_rst_e17", 32'(rst_a),  32'h0);
    goto_e(e1 + 17);  check("p1_rst_e18", 32'(rst_a),  32'h1);
    goto_e(e1 + 33);  check("p1_rst_e34", 32'(rst_a),  32'h3);
    goto_e(e1 + 49);  check("p1_rst_e50", 32'(rst_a),  32'h7);
    goto_e(e1 + 64);  check("p1_rst_e65", 32'(rst_a),  32'h7);
                      check("p1_done_e65", 32'(done_a), 32'h0);
                      check("p1_busy_e65", 32'(busy_a), 32'h1);
    goto_e(e1 + 65);  check("p1_rst_e66", 32'(rst_a),  32'hf);
                      check("p1_done_e66", 32'(done_a), 32'h1);
                      check("p1_busy_e66", 32'(busy_a), 32'h0);

    // Asynchronous assertion mid-sequence, then full re-release
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_rst();
    goto_e(e1 + 39);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_a",  32'(rst_a),  32'h0);
    check("async_busy_a", 32'(busy_a), 32'h0);
    check("async_done_a", 32'(done_a), 32'h0);
    check("async_rst_b",  32'(rst_b),  32'h0);
    repeat (3) @(negedge clk);
    release_rst();
    goto_e(e1 + 16);  check("p2_rst_e17", 32'(rst_a), 32'h0);
    goto_e(e1 + 17);  check("p2_rst_e18", 32'(rst_a), 32'h1);
    goto_e(e1 + 65);  check("p2_rst_e66", 32'(rst_a), 32'hf);

    // Software reset from ST_DONE
    ex = edge_n + 5;
    pulse_sw_at(ex, 1);
    check("sw_rst_ex",  32'(rst_a),  32'h0);
    check("sw_done_ex", 32'(done_a), 32'h0);
    check("sw_busy_ex", 32'(busy_a), 32'h1);
    goto_e(ex + 15);  check("sw_rst_x15", 32'(rst_a), 32'h0);
    goto_e(ex + 16);  check("sw_rst_x16", 32'(rst_a), 32'h1);
    goto_e(ex + 32);  check("sw_rst_x32", 32'(rst_a), 32'h3);
    goto_e(ex + 64);  check("sw_rst_x64", 32'(rst_a), 32'hf);
                      check("sw_done_x64", 32'(done_a), 32'h1);

    // Held software reset for 10 cycles
    ex = edge_n + 5;
    pulse_sw_at(ex, 10);
    last = ex + 9;
    check("held_rst",  32'(rst_a),  32'h0);
    check("held_busy", 32'(busy_a), 32'h1);
    goto_e(last + 15); check("held_rst_15", 32'(rst_a), 32'h0);
    goto_e(last + 16); check("held_rst_16", 32'(rst_a), 32'h1);

    // Collision: software reset on the edge that would release bit 1
    col = last + 32;
    goto_e(col - 1);  check("col_pre", 32'(rst_a), 32'h1);
    @(negedge clk); sw = 1'b1;
    @(negedge clk); sw = 1'b0;
    check("col_clear", 32'(rst_a), 32'h0);
    goto_e(col + 15); check("col_rst_15", 32'(rst_a), 32'h0);
    goto_e(col + 16); check("col_rst_16", 32'(rst_a), 32'h1);

    // Software reset during ST_HOLD is ignored
    @(negedge clk); rst_n = 1'b0; sw = 1'b1;
    repeat (2) @(negedge clk);
    release_rst();
    goto_e(e1 + 1);   check("hold_busy_e2", 32'(busy_a), 32'h1);
    @(negedge clk); sw = 1'b0;
    goto_e(e1 + 16);  check("hold_rst_e17", 32'(rst_a), 32'h0);
    goto_e(e1 + 17);  check("hold_rst_e18", 32'(rst_a), 32'h1);

    // Randomised traffic against the model
    quiet = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((i % 100) == 0) quiet = ~quiet;
      sw = quiet ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 7) == 0);
      r = int'($urandom_range(0, 299));
      if (r == 0) begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_n = 1'b1;
      end else if (r == 1) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    sw = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised reset synchroniser and sequencer. It takes the chip-level asynchronous active-low reset and produces NUM_OUT active-low reset outputs. Every output asserts asynchronously together. Outputs release synchronously to i_clkin one at a time, in index order, with a programmable gap between them. A synchronous software reset request restarts the whole sequence. It sits at the top of each clock domain and replaces the fixed 2-flop reset synchroniser where staged release of sub-blocks (e.g. bus fabric before peripherals) is needed.

## Interface
- SYNC_STAGES, 2, synchroniser depth; legal range ≥2.
- NUM_OUT, 4, number of sequenced reset outputs; legal range ≥1.
- STEP_CYCLES, 16, clock cycles between consecutive releases; legal range ≥1.
- i_clkin  input  1  clock. Single clock domain for the whole block.
- i_reset  input  1  asynchronous active-low reset. Asserts asynchronously; release is synchronised internally.
- i_sw_rst  input  1  synchronous active-high software reset request. Sampled on the rising edge of i_clkin.
- o_reset  output  NUM_OUT  active-low resets. Bit 0 is released first.
- o_done  output  1  high when every o_reset bit is released.
- o_busy  output  1  high while a release sequence is in progress.

## Operation
- Synchroniser chain:
  - SYNC_STAGES flops, all asynchronously cleared by i_reset low.
  - First stage D input is 1'b1; each later stage takes the previous stage.
  - Output r_rel is the last stage.
- FSM states:
  - ST_HOLD: waits for r_rel=1.
  - ST_STEP: counts STEP_CYCLES; when the count completes, releases o_reset[idx] and increments idx.
  - ST_DONE: all outputs released.
- Transitions:
  - ST_HOLD to ST_STEP when r_rel=1. Count and idx are cleared on entry.
  - ST_STEP to ST_STEP after each release while idx<NUM_OUT-1.
  - ST_STEP to ST_DONE on the release of bit NUM_OUT-1.
- i_sw_rst=1 at an edge, in ST_STEP or ST_DONE:
  - At that edge, all o_reset go to 0, o_done goes to 0, o_busy goes to 1.
  - The FSM goes to ST_STEP with count=0 and idx=0.
  - If i_sw_rst stays high, the sequence restarts at every edge, so timing is measured from the last edge with i_sw_rst=1.
- i_sw_rst is ignored in ST_HOLD, because the domain is already held in reset.
- i_reset low at any time, including mid-sequence or mid-software-reset:
  - All flops clear asynchronously.
  - o_reset becomes all 0, o_done 0, o_busy 0, and the FSM returns to ST_HOLD.
- Reset values: o_reset = {NUM_OUT{1'b0}}, o_done = 0, o_busy = 0.
- Register rules:
  - Every output is a register. No combinational path from any input to o_reset except the asynchronous clear.
  - Each o_reset bit only goes 0 to 1 at the edge that releases it; it never glitches.
  - Released bits stay released until the next reset event.
- Widths:
  - Counter is $clog2(STEP_CYCLES+1) bits and never wraps; it reloads on each release.
  - idx is $clog2(NUM_OUT+1) bits.
  - Neither counter ever exceeds its terminal value.

## Timing
- Release after i_reset: let E1 be the first rising edge that samples i_reset high.
  - r_rel goes high at edge E(SYNC_STAGES).
  - o_reset[k] goes high at edge E(SYNC_STAGES + (k+1)·STEP_CYCLES).
  - o_done goes high at the same edge as o_reset[NUM_OUT-1].
- o_busy: rises at edge E(SYNC_STAGES) and falls at the same edge o_done rises.
- Release after software reset: let Ex be the last edge with i_sw_rst=1.
  - o_reset[k] goes high at edge Ex + (k+1)·STEP_CYCLES.
  - o_done goes high with the last release.
- Minimum reset pulse width: every output is held low for at least STEP_CYCLES cycles after any reset event.
- Assertion latency:
  - i_reset falling edge to outputs low: asynchronous, no clock required.
  - i_sw_rst to outputs low: 1 edge.
- Simultaneous events:
  - i_sw_rst on the same edge a release would occur: the software reset wins and no bit is released.
  - i_reset low overrides everything.
  - A short glitch on i_reset still clears all flops. This is intended behaviour.

## Structure
- Shared package/header rst_seq_pkg holds:
  - the state encodings ST_HOLD, ST_STEP, ST_DONE;
  - the default parameter constants.
- One sub-module, rst_sync_chain:
  - parametrised by SYNC_STAGES;
  - ports i_clkin, i_reset, o_reset.
  - It generalises the fixed 2-flop synchroniser and is reusable on its own.
- Top-level rst_seq_ctrl contains the FSM, counter, idx and output registers.

## Test plan
All scenarios use the defaults SYNC_STAGES=2, NUM_OUT=4, STEP_CYCLES=16.
- Power-on release: i_reset low for 5 cycles, then high.
  - o_reset = 4'b0000 until E18.
  - o_reset[0] rises at E18, then bits 1, 2, 3 at E34, E50, E66.
  - o_done and o_busy change at E66; o_busy is high from E2.
- Asynchronous assertion mid-sequence: pull i_reset low at E40, between clock edges.
  - o_reset = 0000 immediately, o_busy = 0, no clock needed.
  - After re-release the full sequence repeats with the same offsets.
- Software reset from ST_DONE: 1-cycle i_sw_rst pulse sampled at edge Ex.
  - o_reset = 0000 and o_done = 0 at Ex.
  - Releases occur at Ex+16, Ex+32, Ex+48, Ex+64.
- Held software reset: i_sw_rst high for 10 cycles.
  - Outputs stay 0000 throughout.
  - First release occurs 16 edges after the last edge that sampled i_sw_rst high.
- Collision and ignore cases:
  - i_sw_rst asserted exactly at E34: o_reset[1] does not rise, and all bits clear.
  - i_sw_rst asserted during ST_HOLD: no effect on the sequence timing.
- Parameter sweep SYNC_STAGES=3, NUM_OUT=1, STEP_CYCLES=1:
  - o_reset[0] and o_done rise at E4.
  - Width checks pass with no counter overflow.
